float_to_int: RTL

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/float_pkg.sv | 43 ++++
 rtl/float_to_int_shift_right_sticky.sv | 43 ++++
 rtl/float_to_int.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// float_pkg
// Shared IEEE-754 format helpers for the float arithmetic blocks
// (float_to_int, add_float). Field widths, bias and the special encodings
// are derived from the total operand width: 32 selects single precision,
// anything else selects double precision.
//
// Contents:
//   float_class_t    operand class produced by unpacking
//   exp_width()      exponent field width
//   fraction_width() stored fraction width (hidden bit excluded)
//   bias()           exponent bias
//   inf_value()      +Inf encoding, right-aligned in 64 bits
//   nan_value()      canonical quiet NaN encoding, right-aligned in 64 bits
package float_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } float_class_t;

    function automatic int exp_width(input int float_width);
        return (float_width == 32) ? 8 : 11;
    endfunction

    function automatic int fraction_width(input int float_width);
        return float_width - exp_width(float_width) - 1;
    endfunction

    function automatic int bias(input int float_width);
        return (1 << (exp_width(float_width) - 1)) - 1;
    endfunction

    function automatic logic [63:0] inf_value(input int float_width);
        return ((64'd1 << exp_width(float_width)) - 64'd1) << fraction_width(float_width);
    endfunction

    function automatic logic [63:0] nan_value(input int float_width);
        return inf_value(float_width) | (64'd1 << (fraction_width(float_width) - 1));
    endfunction

endpackage

// File: rtl/float_to_int_shift_right_sticky.sv
// shift_right_sticky
// Combinational logical right shifter that also reports the first bit
// shifted out (guard) and the OR of every bit below it (sticky).
// Shift amounts larger than WIDTH shift everything out: the result and
// guard are zero and sticky is the OR of the whole input.
//
// Ports:
//   value    [WIDTH-1:0]      operand
//   amt      [AMT_WIDTH-1:0]  right shift amount
//   shifted  [WIDTH-1:0]      value >> amt
//   guard                     bit amt-1 of value (0 when amt is 0)
//   sticky                    OR of bits below amt-1
module shift_right_sticky #(
    parameter int WIDTH     = 53,
    parameter int AMT_WIDTH = 6
) (
    input  logic [WIDTH-1:0]     value,
    input  logic [AMT_WIDTH-1:0] amt,
    output logic [WIDTH-1:0]     shifted,
    output logic                 guard,
    output logic                 sticky
);

    // The shifted-out bits land in the lower half of the double-width
    // vector, so guard and sticky fall out of fixed bit positions.
    logic [2*WIDTH-1:0] wide;

    always_comb begin
        wide    = '0;
        shifted = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        if (int'(amt) > WIDTH) begin
            sticky = |value;
        end else begin
            wide    = {value, {WIDTH{1'b0}}} >> amt;
            shifted = wide[2*WIDTH-1:WIDTH];
            guard   = wide[WIDTH-1];
            sticky  = |wide[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/float_to_int.sv
// float_to_int
// Multi-cycle IEEE float to signed integer converter. A request is
// accepted on any clock edge with start=1 (a request while busy aborts the
// conversion in flight) and the result is loaded four edges later, when the
// FSM leaves PACK. Denormals convert as zero, NaN gives 0 with nan_reg,
// and out-of-range values saturate with overflow_reg.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   start         conversion request
//   round_mode    0 truncate toward zero, 1 round to nearest even
//   op            float operand (FLOAT_WIDTH bits)
//   out_reg       signed integer result (INT_WIDTH bits)
//   nan_reg       operand was NaN
//   overflow_reg  result saturated
//   inexact_reg   discarded fraction was nonzero
//   zero_reg      result is zero
//   done_reg      result valid, held until the next accepted start
//   busy          conversion in progress
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// UNPACK | classify operand, split sign/exponent/mantissa
// SHIFT  | align mantissa to integer, derive guard and sticky
// ROUND  | apply rounding increment, negate for negative operands
// PACK   | saturation and flags; results load on the exit edge
module float_to_int
    import float_pkg::*;
#(
    parameter int FLOAT_WIDTH = 64,
    parameter int INT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   round_mode,
    input  logic [FLOAT_WIDTH-1:0] op,
    output logic [INT_WIDTH-1:0]   out_reg,
    output logic                   nan_reg,
    output logic                   overflow_reg,
    output logic                   inexact_reg,
    output logic                   zero_reg,
    output logic                   done_reg,
    output logic                   busy
);

    localparam int EXP_WIDTH      = exp_width(FLOAT_WIDTH);
    localparam int FRACTION_WIDTH = fraction_width(FLOAT_WIDTH);
    localparam int BIAS           = bias(FLOAT_WIDTH);
    localparam int MANT_WIDTH     = FRACTION_WIDTH + 1;
    localparam int EXP_S_WIDTH    = EXP_WIDTH + 2;
    localparam int MAG_WIDTH      = INT_WIDTH + 1;
    localparam int AMT_WIDTH      = $clog2(MANT_WIDTH + 2);

    // Magnitude (sign stripped) of +Inf; anything above it is a NaN.
    localparam logic [FLOAT_WIDTH-2:0] INF_MAG =
        (FLOAT_WIDTH-1)'(inf_value(FLOAT_WIDTH));
    localparam logic signed [EXP_S_WIDTH-1:0] BIAS_S = EXP_S_WIDTH'(BIAS);

    localparam logic [MAG_WIDTH-1:0] HALF    = {2'b01, {(INT_WIDTH-1){1'b0}}};
    localparam logic [INT_WIDTH-1:0] MAX_POS = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] MIN_NEG = {1'b1, {(INT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_ROUND,
        S_PACK
    } state_t;

    state_t state_q, state_d;

    // captured request
    logic [FLOAT_WIDTH-1:0] op_q;
    logic                   rm_q;

    // UNPACK results
    logic                          sign_q;
    float_class_t                  cls_q, cls_d;
    logic signed [EXP_S_WIDTH-1:0] exp_q, exp_d;
    logic [MANT_WIDTH-1:0]         mant_q;
    logic                          frac_nz_q;

    // SHIFT results
    logic [MAG_WIDTH-1:0] mag_q, mag_d;
    logic                 guard_q, guard_d;
    logic                 sticky_q, sticky_d;
    logic                 big_q, big_d;

    // ROUND results
    logic [MAG_WIDTH-1:0] rnd_mag_q, rnd_mag_d;
    logic [INT_WIDTH-1:0] rnd_val_q, rnd_val_d;
    logic                 round_inc;

    // PACK results
    logic [INT_WIDTH-1:0] res_d;
    logic                 nan_d, ovf_d, inexact_d, zero_d;

    logic [EXP_WIDTH-1:0]      exp_field;
    logic [FRACTION_WIDTH-1:0] frac_field;

    int                    e_int;
    int                    rsh_int;
    int                    lamt;
    logic [AMT_WIDTH-1:0]  shift_amt;
    logic [MANT_WIDTH-1:0] sh_out;
    logic                  sh_guard;
    logic                  sh_sticky;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_UNPACK;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_UNPACK: state_d = S_SHIFT;
                S_SHIFT:  state_d = S_ROUND;
                S_ROUND:  state_d = S_PACK;
                S_PACK:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);

    // ---------------- UNPACK ----------------
    assign exp_field  = op_q[FLOAT_WIDTH-2 -: EXP_WIDTH];
    assign frac_field = op_q[FRACTION_WIDTH-1:0];

    always_comb begin
        if (op_q[FLOAT_WIDTH-2:0] > INF_MAG) begin
            cls_d = CLS_NAN;
        end else if (op_q[FLOAT_WIDTH-2:0] == INF_MAG) begin
            cls_d = CLS_INF;
        end else if (exp_field == '0) begin
            cls_d = CLS_ZERO;
        end else begin
            cls_d = CLS_NORMAL;
        end
        exp_d = $signed({2'b00, exp_field}) - BIAS_S;
    end

    // ---------------- SHIFT ----------------
    // rsh_int > 0: the binary point sits inside the mantissa, shift right.
    // rsh_int <= 0: the whole mantissa is integer, shift left (exact).
    // Right shifts are clamped just past the mantissa so everything
    // lands in sticky for tiny exponents.
    always_comb begin
        e_int   = int'(exp_q);
        rsh_int = FRACTION_WIDTH - e_int;
        lamt    = 0;
        if (rsh_int > MANT_WIDTH + 1) begin
            shift_amt = AMT_WIDTH'(MANT_WIDTH + 1);
        end else if (rsh_int > 0) begin
            shift_amt = AMT_WIDTH'(rsh_int);
        end else begin
            shift_amt = '0;
            lamt      = -rsh_int;
        end
    end

    shift_right_sticky #(
        .WIDTH     (MANT_WIDTH),
        .AMT_WIDTH (AMT_WIDTH)
    ) u_shift (
        .value   (mant_q),
        .amt     (shift_amt),
        .shifted (sh_out),
        .guard   (sh_guard),
        .sticky  (sh_sticky)
    );

    always_comb begin
        mag_d    = '0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        big_d    = 1'b0;
        case (cls_q)
            CLS_NORMAL: begin
                // e >= INT_WIDTH is at least 2^INT_WIDTH: saturates
                // whatever the sign, so skip alignment entirely.
                if (e_int >= INT_WIDTH) begin
                    big_d = 1'b1;
                end else if (rsh_int <= 0) begin
                    mag_d = MAG_WIDTH'(mant_q) << lamt;
                end else begin
                    mag_d    = MAG_WIDTH'(sh_out);
                    guard_d  = sh_guard;
                    sticky_d = sh_sticky;
                end
            end
            CLS_ZERO: sticky_d = frac_nz_q;
            CLS_INF:  big_d    = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- ROUND ----------------
    always_comb begin
        round_inc = rm_q & guard_q & (sticky_q | mag_q[0]);
        rnd_mag_d = mag_q + MAG_WIDTH'(round_inc);
        rnd_val_d = sign_q ? (INT_WIDTH'(0) - rnd_mag_d[INT_WIDTH-1:0])
                           : rnd_mag_d[INT_WIDTH-1:0];
    end

    // ---------------- PACK ----------------
    // The negative range reaches one further than the positive range, so
    // -2^(INT_WIDTH-1) exactly is still representable.
    always_comb begin
        nan_d = (cls_q == CLS_NAN);
        ovf_d = 1'b0;
        if (!nan_d) begin
            ovf_d = big_q | (sign_q ? (rnd_mag_q > HALF) : (rnd_mag_q >= HALF));
        end
        if (nan_d) begin
            res_d = '0;
        end else if (ovf_d) begin
            res_d = sign_q ? MIN_NEG : MAX_POS;
        end else begin
            res_d = rnd_val_q;
        end
        inexact_d = ~nan_d & ~ovf_d & (guard_q | sticky_q);
        zero_d    = ~nan_d & (res_d == '0);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            rm_q      <= 1'b0;
            sign_q    <= 1'b0;
            cls_q     <= CLS_ZERO;
            exp_q     <= '0;
            mant_q    <= '0;
            frac_nz_q <= 1'b0;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            big_q     <= 1'b0;
            rnd_mag_q <= '0;
            rnd_val_q <= '0;
        end else begin
            if (start) begin
                op_q <= op;
                rm_q <= round_mode;
            end
            if (state_q == S_UNPACK) begin
                sign_q    <= op_q[FLOAT_WIDTH-1];
                cls_q     <= cls_d;
                exp_q     <= exp_d;
                mant_q    <= {exp_field != '0, frac_field};
                frac_nz_q <= |frac_field;
            end
            if (state_q == S_SHIFT) begin
                mag_q    <= mag_d;
                guard_q  <= guard_d;
                sticky_q <= sticky_d;
                big_q    <= big_d;
            end
            if (state_q == S_ROUND) begin
                rnd_mag_q <= rnd_mag_d;
                rnd_val_q <= rnd_val_d;
            end
        end
    end

    // ---------------- result registers ----------------
    // A start in PACK is an abort, so it wins over the result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg      <= '0;
            nan_reg      <= 1'b0;
            overflow_reg <= 1'b0;
            inexact_reg  <= 1'b0;
            zero_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (start) begin
            done_reg <= 1'b0;
        end else if (state_q == S_PACK) begin
            out_reg      <= res_d;
            nan_reg      <= nan_d;
            overflow_reg <= ovf_d;
            inexact_reg  <= inexact_d;
            zero_reg     <= zero_d;
            done_reg     <= 1'b1;
        end
    end

endmodule
